// File: rtl/arb_pkg.sv
`default_nettype none
// ==== arb_pkg : shared types and constants for arb_pkt_mux (rev 1.0) ====
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/arbiter.sv
`default_nettype none
// ==== arbiter : combinational fixed-priority arbiter, lowest index wins (rev 1.0) ====
module arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  // Isolate the lowest set bit: req & -req
  assign gnt_o = req_i & (~req_i + {{(NUM_PORTS-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/arb_pkt_mux.sv
`default_nettype none
// ==== arb_pkt_mux : packet-locked fixed-priority N:1 beat mux with registered output (rev 1.0) ====
module arb_pkt_mux
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_last,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [CNT_W-1:0]            pkt_cnt
);

  state_t                 r_state;
  logic [NUM_PORTS-1:0]   r_gnt;
  logic                   r_out_valid;
  logic [DATA_W-1:0]      r_out_data;
  logic                   r_out_last;
  logic [CNT_W-1:0]       r_pkt_cnt;

  logic [NUM_PORTS-1:0]   w_arb_gnt;
  logic                   w_out_free;
  logic                   w_xfer;
  logic [DATA_W-1:0]      w_mux_data;
  logic                   w_mux_last;
  logic [DATA_W-1:0]      w_masked [NUM_PORTS];

  arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arbiter (
    .req_i (in_valid),
    .gnt_o (w_arb_gnt)
  );

  assign w_out_free = ~r_out_valid | out_ready;
  assign in_ready   = (r_state == LOCKED) ? (r_gnt & {NUM_PORTS{w_out_free}}) : '0;
  assign w_xfer     = |(in_valid & in_ready);

  // Owner is one-hot, so masking each lane and OR-ing selects it directly
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_mux
    assign w_masked[i] = in_data[i*DATA_W +: DATA_W] & {DATA_W{r_gnt[i]}};
  end

  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_mux_data = w_mux_data | w_masked[i];
    end
  end

  assign w_mux_last = |(in_last & r_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|in_valid) begin
            r_gnt   <= w_arb_gnt;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer && w_mux_last) begin
            r_gnt     <= '0;
            r_state   <= IDLE;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_last  <= w_mux_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign gnt_o     = r_gnt;
  assign pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arb_pkt_mux.sv
`default_nettype none
// ==== tb_arb_pkt_mux : directed self-checking bench for arb_pkt_mux (rev 1.0) ====
module tb_arb_pkt_mux;

  localparam int NP = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NP-1:0]    in_valid;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_last;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             out_ready;
  logic [NP-1:0]    gnt_o;
  logic [15:0]      pkt_cnt;

  int vec = 0;
  int mis = 0;

  arb_pkt_mux #(
    .NUM_PORTS (NP),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .gnt_o     (gnt_o),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    in_valid[p]          = v;
    in_data[p*DW +: DW]  = d;
    in_last[p]           = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] d, input logic l);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;

    // Asynchronous reset asserted before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_gnt",   {28'd0, gnt_o},    32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_last",  {31'd0, out_last},  32'd0);
    chk("rst_cnt",   {16'd0, pkt_cnt},   32'd0);
    chk("rst_rdy",   {28'd0, in_ready},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Ports 1 and 3 contend; port 1 wins, port 3 follows after a bubble
    drv(1, 1'b1, 8'h11, 1'b0);
    drv(3, 1'b1, 8'h31, 1'b0);
    #1;
    chk("s1_idle_gnt", {28'd0, gnt_o},    32'd0);
    chk("s1_idle_rdy", {28'd0, in_ready}, 32'd0);
    cyc();
    chk("s1_gnt1",  {28'd0, gnt_o},     32'h2);
    chk("s1_rdy1",  {28'd0, in_ready},  32'h2);
    chk("s1_ov1",   {31'd0, out_valid}, 32'd0);
    cyc();
    chk_out("s1_b1", 8'h11, 1'b0);
    drv(1, 1'b1, 8'h12, 1'b0);
    cyc();
    chk_out("s1_b2", 8'h12, 1'b0);
    drv(1, 1'b1, 8'h13, 1'b1);
    cyc();
    chk_out("s1_b3", 8'h13, 1'b1);
    chk("s1_gnt_bubble", {28'd0, gnt_o},   32'd0);
    chk("s1_cnt1",       {16'd0, pkt_cnt}, 32'd1);
    drv(1, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("s1_gnt3", {28'd0, gnt_o},     32'h8);
    chk("s1_ov5",  {31'd0, out_valid}, 32'd0);
    cyc();
    chk_out("s1_p3b1", 8'h31, 1'b0);
    drv(3, 1'b1, 8'h32, 1'b0);
    cyc();
    chk_out("s1_p3b2", 8'h32, 1'b0);
    drv(3, 1'b1, 8'h33, 1'b1);
    cyc();
    chk_out("s1_p3b3", 8'h33, 1'b1);
    chk("s1_cnt2",    {16'd0, pkt_cnt}, 32'd2);
    chk("s1_gnt_end", {28'd0, gnt_o},   32'd0);
    drv(3, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("s1_ov_end", {31'd0, out_valid}, 32'd0);

    // Port 2 locked; higher-priority port 0 arrives mid-packet and must wait
    drv(2, 1'b1, 8'h21, 1'b0);
    cyc();
    chk("s2_gnt2", {28'd0, gnt_o}, 32'h4);
    cyc();
    chk_out("s2_b1", 8'h21, 1'b0);
    drv(0, 1'b1, 8'h01, 1'b0);
    drv(2, 1'b1, 8'h22, 1'b0);
    #1;
    chk("s2_rdy_a", {28'd0, in_ready}, 32'h4);
    cyc();
    chk_out("s2_b2", 8'h22, 1'b0);
    chk("s2_gnt_hold", {28'd0, gnt_o}, 32'h4);
    drv(2, 1'b1, 8'h23, 1'b1);
    #1;
    chk("s2_rdy_b", {28'd0, in_ready}, 32'h4);
    cyc();
    chk_out("s2_b3", 8'h23, 1'b1);
    chk("s2_gnt_bubble", {28'd0, gnt_o},   32'd0);
    chk("s2_cnt3",       {16'd0, pkt_cnt}, 32'd3);
    drv(2, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("s2_gnt0", {28'd0, gnt_o},    32'h1);
    chk("s2_rdy0", {28'd0, in_ready}, 32'h1);

    // Downstream stall while port 0 owns the output
    cyc();
    chk_out("s3_b1", 8'h01, 1'b0);
    drv(0, 1'b1, 8'h02, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("s3_rdy_stall", {28'd0, in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out("s3_hold", 8'h01, 1'b0);
      chk("s3_rdy_hold", {28'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("s3_rdy_resume", {28'd0, in_ready}, 32'h1);
    cyc();
    chk_out("s3_b2", 8'h02, 1'b0);
    drv(0, 1'b1, 8'h03, 1'b0);
    cyc();
    chk_out("s3_b3", 8'h03, 1'b0);

    // Owner drops valid for three cycles; grant must persist
    drv(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s4_ov_gap",  {31'd0, out_valid}, 32'd0);
      chk("s4_gnt_gap", {28'd0, gnt_o},     32'h1);
    end
    drv(0, 1'b1, 8'h04, 1'b1);
    cyc();
    chk_out("s4_b4", 8'h04, 1'b1);
    chk("s4_gnt_end", {28'd0, gnt_o},   32'd0);
    chk("s4_cnt4",    {16'd0, pkt_cnt}, 32'd4);
    drv(0, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("s4_ov_end", {31'd0, out_valid}, 32'd0);

    // Reset pulsed between edges with a held beat in the output register
    drv(1, 1'b1, 8'h41, 1'b0);
    cyc();
    chk("s5_gnt1", {28'd0, gnt_o}, 32'h2);
    cyc();
    chk_out("s5_b1", 8'h41, 1'b0);
    drv(1, 1'b1, 8'h42, 1'b0);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_gnt",  {28'd0, gnt_o},     32'd0);
    chk("s5_rst_ov",   {31'd0, out_valid}, 32'd0);
    chk("s5_rst_data", {24'd0, out_data},  32'd0);
    chk("s5_rst_last", {31'd0, out_last},  32'd0);
    chk("s5_rst_cnt",  {16'd0, pkt_cnt},   32'd0);
    chk("s5_rst_rdy",  {28'd0, in_ready},  32'd0);
    @(negedge clk);
    drv(1, 1'b0, 8'h00, 1'b0);
    drv(3, 1'b1, 8'h51, 1'b1);
    out_ready = 1'b1;
    rst = 1'b0;
    cyc();
    chk("s5_gnt3", {28'd0, gnt_o},     32'h8);
    chk("s5_ov",   {31'd0, out_valid}, 32'd0);
    cyc();
    chk_out("s5_single", 8'h51, 1'b1);
    chk("s5_cnt1",    {16'd0, pkt_cnt}, 32'd1);
    chk("s5_gnt_end", {28'd0, gnt_o},   32'd0);
    drv(3, 1'b0, 8'h00, 1'b0);

    // Counter preloaded to its maximum; next completion must wrap to zero
    force dut.r_pkt_cnt = 16'hFFFF;
    #1;
    release dut.r_pkt_cnt;
    #1;
    chk("s6_preload", {16'd0, pkt_cnt}, 32'hFFFF);
    drv(0, 1'b1, 8'h61, 1'b1);
    cyc();
    chk("s6_gnt0", {28'd0, gnt_o}, 32'h1);
    cyc();
    chk_out("s6_single", 8'h61, 1'b1);
    chk("s6_wrap", {16'd0, pkt_cnt}, 32'd0);
    drv(0, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("s6_ov_end",  {31'd0, out_valid}, 32'd0);
    chk("s6_gnt_end", {28'd0, gnt_o},     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_pkt_mux.md
ARB_PKT_MUX -- requirements
Module: arb_pkt_mux

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, number of requesting ports (>=2).
REQ-002 The block SHALL have parameter DATA_W, default 8, beat data width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, NUM_PORTS, per-port beat valid.
REQ-006 The block SHALL have port in_data, input, NUM_PORTS*DATA_W, per-port beat data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port in_last, input, NUM_PORTS, per-port last beat of packet.
REQ-008 The block SHALL have port in_ready, output, NUM_PORTS, per-port beat accept.
REQ-009 The block SHALL have ports out_valid (output, 1), out_data (output, DATA_W) and out_last (output, 1), forming the registered output beat.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-011 The block SHALL have port gnt_o, output, NUM_PORTS, one-hot current packet owner; all-zero when idle.
REQ-012 The block SHALL have port pkt_cnt, output, 16, count of completed packets accepted from inputs.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and LOCKED.
REQ-014 In IDLE with any in_valid set, the block SHALL pick the lowest-index asserted port (fixed priority), load gnt_o with that one-hot value and enter LOCKED on the next edge; no beat transfers in IDLE.
REQ-015 In IDLE with in_valid all zero, the block SHALL remain in IDLE with gnt_o = 0.
REQ-016 In_ready[i] SHALL equal (state==LOCKED) & gnt_o[i] & (~out_valid | out_ready); all non-owner in_ready bits SHALL be 0.
REQ-017 An input beat SHALL transfer when in_valid[i] & in_ready[i]; its data and last SHALL load the output register on that edge and out_valid SHALL be 1 the following cycle.
REQ-018 Out_valid SHALL clear on an edge where out_ready=1 and no new beat transfers.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_last SHALL be held stable.
REQ-020 With out_ready held high, the block SHALL sustain one beat per cycle within a packet.
REQ-021 A transferred beat with in_last=1 SHALL return the FSM to IDLE, clear gnt_o and increment pkt_cnt on the same edge; the following cycle is an arbitration bubble.
REQ-022 Pkt_cnt SHALL wrap from 16'hFFFF to 0.
REQ-023 In LOCKED, requests from other ports (including higher priority) SHALL be ignored until the owner's last beat transfers.
REQ-024 If the owner deasserts in_valid mid-packet, the block SHALL remain LOCKED, waiting indefinitely.
REQ-025 A single-beat packet (in_last=1 on first beat) SHALL be handled identically: LOCKED for exactly one transfer.
REQ-026 First-beat latency SHALL be 2 cycles: in_valid seen in IDLE at cycle T yields out_valid=1 at cycle T+2 when the output register is free.

Reset
REQ-027 Rst assertion SHALL immediately force state=IDLE, gnt_o=0, out_valid=0, out_data=0, out_last=0 and pkt_cnt=0, regardless of clk.
REQ-028 Reset mid-packet SHALL discard the partial packet and the held output beat; no pkt_cnt increment.
REQ-029 After rst deassertion, arbitration SHALL resume from IDLE on the first rising edge.

Structure
REQ-030 Package arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the pkt_cnt width constant (16).
REQ-031 Fixed-priority selection SHALL instantiate the existing combinational arbiter module arbiter (NUM_PORTS passed through) with in_valid as req_i; its gnt_o is sampled only in IDLE.
REQ-032 The data/last mux SHALL be an AND-OR over the one-hot owner, with no priority encoder re-derivation.

Verification
REQ-033 Ports 1 and 3 raise valid in cycle 0, 3-beat packets, out_ready=1 -> gnt_o=4'b0010 from cycle 1, port-1 beats out in cycles 2-4, bubble, then port 3 granted; pkt_cnt=2.
REQ-034 Port 2 locked; port 0 raises valid mid-packet -> port 0 in_ready stays 0 until port 2 last transfers; port 0 granted next.
REQ-035 Out_ready=0 for 5 cycles mid-packet -> out_data/out_last stable, in_ready[owner]=0, no beat lost or duplicated.
REQ-036 Owner drops in_valid for 3 cycles mid-packet -> gnt_o unchanged, no transfers, resumes correctly.
REQ-037 Rst pulsed mid-packet between clock edges -> outputs zero immediately, pkt_cnt=0, next packet arbitrated fresh.
REQ-038 Preload 65535 single-beat packets -> pkt_cnt wraps to 0 on next completion.
